scanner_link_arbiter: RTL and testbench
=======================================

Name: scanner_link_arbiter

Overview:
Owns the single shared serial command/data link. Two scanner channels request it, and a round-robin arbiter grants one at a time. Each granted frame (command byte, optionally followed by a data byte) is serialised LSB-first with a divided bit clock. The block sits between the scanner channels and the output driver, and replaces per-scanner ad-hoc drive of clkOut/dataOut.

Parameters:
BIT_DIV, 4, clk cycles per serial bit; even, >=2; link_clk high for the first BIT_DIV/2 cycles of each bit.
GAP_CYCLES, 2, idle clk cycles forced between frames; 0 allowed.

Ports:
clk  input  1  system clock; all state on posedge.
rst  input  1  asynchronous, active-high reset.
req  input  2  per-channel request level; bit i = scanner i.
req_has_data  input  2  bit i: frame for channel i carries a data byte after the command.
req_cmd0  input  8  channel 0 command byte (2=ready, 3=start, 4=full, 7=data follows).
req_cmd1  input  8  channel 1 command byte.
req_data0  input  8  channel 0 data byte.
req_data1  input  8  channel 1 data byte.
grant  output  2  one-hot; held for the whole frame of the served channel.
done  output  2  one-cycle pulse on the served channel's bit after its last bit completes.
link_clk  output  1  serial bit clock; 0 when not shifting.
link_data  output  1  serial data; 0 when not shifting.
link_busy  output  1  1 in SHIFT and GAP.

Behaviour:
- Reset (async, immediate, including mid-frame): state=IDLE; grant=0, done=0, link_clk=0, link_data=0, link_busy=0; last_served=1, so channel 0 wins the first tie; div_cnt=0, bit_cnt=0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - If req!=0 at a posedge, go to SHIFT on that edge.
  - Winner: the only requester if one is active; otherwise the channel != last_served.
  - Same edge: set grant one-hot, update last_served, latch cmd/data/has_data into a 16-bit shift register, frame_len = 8 or 16.
  - Latency: req high at edge N -> grant and first bit on link_data valid after edge N.
- SHIFT:
  - div_cnt counts 0..BIT_DIV-1.
  - link_data = current LSB, stable for the whole bit.
  - link_clk = 1 while div_cnt < BIT_DIV/2.
  - At div_cnt==BIT_DIV-1: shift right, increment bit_cnt.
  - When the last bit ends (bit_cnt==frame_len-1 and div_cnt==BIT_DIV-1): pulse done[winner] next cycle, drop grant, link_clk=0, link_data=0.
  - Then go to GAP, or to IDLE if GAP_CYCLES==0.
- Frame duration: frame_len*BIT_DIV cycles (8-bit frame, BIT_DIV=4: 32 cycles).
- GAP: link_busy=1, grant=0; count GAP_CYCLES, then IDLE. req is ignored during GAP.
- req is level-sensitive:
  - Requester drops req on seeing done.
  - req still high when returning to IDLE = new request; arbitration uses updated last_served, so alternating service is guaranteed under continuous contention.
- req or payload changing during SHIFT is ignored; the frame completes with latched values.
- req_has_data is sampled only at grant.
- bit_cnt is 5 bits wide; div_cnt is wide enough for BIT_DIV-1; no wrap occurs within a frame.

Optional Feature:
SCANNER_LINK_PARITY_EN:
- When defined, an even-parity bit follows each byte (after bit 7 of cmd and after bit 7 of data). frame_len becomes 9 or 18; parity = XOR of that byte's 8 bits.
- When undefined, frames are exactly 8 or 16 bits and no parity logic exists.

Decomposition:
- Package scanner_link_pkg:
  - state enum {IDLE, SHIFT, GAP};
  - command constants CMD_READY=8'd2, CMD_START=8'd3, CMD_FULL=8'd4, CMD_DATA=8'd7;
  - widths of bit_cnt and div_cnt.
- One sub-module, scanner_link_serializer: owns div_cnt, the shift register, bit_cnt, link_clk/link_data and parity insertion. It has a load/frame_len input and a last-bit done output.
- The arbiter FSM and round-robin logic stay in the top module.

Test Plan:
- Reset then req=01, cmd0=8'h03, no data -> grant=01 next cycle; link_data shows 1,1,0,0,0,0,0,0, each bit 4 cycles with link_clk high 2/low 2; done=01 pulse at cycle 33; link_busy stays high 2 more cycles.
- req=11 from reset, both without data -> channel 0 served first, then channel 1 after the gap; continuous req=11 for 4 frames -> grant order 01,10,01,10.
- req=10, has_data=10, cmd1=8'h07, data1=8'hA5 -> 16 bits: 07 LSB-first then A5 LSB-first; 64 cycles; done=10.
- Assert rst at bit 3 of a frame -> same cycle link_clk=0, link_data=0, grant=0; after release with req=11, channel 0 wins.
- req0 dropped and cmd0 changed mid-frame -> frame completes with latched value; done still pulses.
- With SCANNER_LINK_PARITY_EN, cmd=8'h07 -> 9 bits, 9th bit=1 (three ones); frame lasts 36 cycles.

Source files
------------

// File: rtl/scanner_link_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// scanner_link_pkg
// Shared definitions for the scanner serial link arbiter:
//   - state_t        : arbiter FSM states
//   - CMD_*          : command byte values the scanners place on the link
//   - BIT_CNT_W      : width of the per-frame bit counter
//   - DIV_CNT_W      : width of the bit-clock divider (supports BIT_DIV <= 256)
//   - SREG_W, LEN_*  : frame shift-register width and frame lengths
// Optional feature macro: SCANNER_LINK_PARITY_EN (even parity bit after
// each byte; frames become 9 or 18 bits instead of 8 or 16).
// ---------------------------------------------------------------------------
package scanner_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] CMD_READY = 8'd2;
    localparam logic [7:0] CMD_START = 8'd3;
    localparam logic [7:0] CMD_FULL  = 8'd4;
    localparam logic [7:0] CMD_DATA  = 8'd7;

    localparam int BIT_CNT_W = 5;
    localparam int DIV_CNT_W = 8;

`ifdef SCANNER_LINK_PARITY_EN
    localparam int                   SREG_W       = 18;
    localparam logic [BIT_CNT_W-1:0] LEN_CMD      = 5'd9;
    localparam logic [BIT_CNT_W-1:0] LEN_CMD_DATA = 5'd18;
`else
    localparam int                   SREG_W       = 16;
    localparam logic [BIT_CNT_W-1:0] LEN_CMD      = 5'd8;
    localparam logic [BIT_CNT_W-1:0] LEN_CMD_DATA = 5'd16;
`endif

endpackage

// File: rtl/scanner_link_arbiter_if.sv
// ---------------------------------------------------------------------------
// scanner_link_arbiter_if
// Bundles the scanner-side request bus and the serial link outputs.
//   req[1:0]           per-channel request level
//   req_has_data[1:0]  channel frame carries a data byte
//   req_cmd0/1         command byte per channel
//   req_data0/1        data byte per channel
//   grant[1:0]         one-hot, held for the served frame
//   done[1:0]          one-cycle pulse after the served frame's last bit
//   link_clk/link_data serial bit clock and data (0 when not shifting)
//   link_busy          link in SHIFT or GAP
// Modports: slave = arbiter side, master = scanner/driver side.
// ---------------------------------------------------------------------------
interface scanner_link_arbiter_if;

    logic [1:0] req;
    logic [1:0] req_has_data;
    logic [7:0] req_cmd0;
    logic [7:0] req_cmd1;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] grant;
    logic [1:0] done;
    logic       link_clk;
    logic       link_data;
    logic       link_busy;

    modport slave (
        input  req, req_has_data, req_cmd0, req_cmd1, req_data0, req_data1,
        output grant, done, link_clk, link_data, link_busy
    );

    modport master (
        output req, req_has_data, req_cmd0, req_cmd1, req_data0, req_data1,
        input  grant, done, link_clk, link_data, link_busy
    );

endinterface

// File: rtl/scanner_link_arbiter_serializer.sv
// ---------------------------------------------------------------------------
// scanner_link_serializer
// Shifts one frame out LSB-first with a divided bit clock.
//   clk, rst   system clock, async active-high reset
//   load       start a frame (captures cmd/data/frame_len)
//   frame_len  number of bits to send
//   cmd, data  payload bytes (data ignored when frame_len covers cmd only)
//   last_bit   high in the final cycle of the final bit
//   link_clk   high for the first BIT_DIV/2 cycles of each bit
//   link_data  current bit, 0 when idle
// With SCANNER_LINK_PARITY_EN defined, an even parity bit follows each byte.
// ---------------------------------------------------------------------------
module scanner_link_serializer
    import scanner_link_pkg::*;
#(
    parameter int BIT_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BIT_CNT_W-1:0] frame_len,
    input  logic [7:0]           cmd,
    input  logic [7:0]           data,
    output logic                 last_bit,
    output logic                 link_clk,
    output logic                 link_data
);

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(BIT_DIV - 1);
    localparam logic [DIV_CNT_W-1:0] DIV_HALF = DIV_CNT_W'(BIT_DIV / 2);

    logic                 active;
    logic [DIV_CNT_W-1:0] div_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] len_last;
    logic [SREG_W-1:0]    sreg;
    logic [SREG_W-1:0]    frame_word;

`ifdef SCANNER_LINK_PARITY_EN
    assign frame_word = {^data, data, ^cmd, cmd};
`else
    assign frame_word = {data, cmd};
`endif

    assign last_bit  = active && (bit_cnt == len_last) && (div_cnt == DIV_LAST);
    assign link_clk  = active && (div_cnt < DIV_HALF);
    assign link_data = active && sreg[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            len_last <= '0;
        end else if (load) begin
            active   <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            len_last <= frame_len - BIT_CNT_W'(1);
        end else if (active) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (last_bit) begin
                    active  <= 1'b0;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                end
            end else begin
                div_cnt <= div_cnt + DIV_CNT_W'(1);
            end
        end
    end

    // Payload register needs no reset: link_data is gated by active.
    always_ff @(posedge clk) begin
        if (load) begin
            sreg <= frame_word;
        end else if (active && (div_cnt == DIV_LAST)) begin
            sreg <= sreg >> 1;
        end
    end

endmodule

// File: rtl/scanner_link_arbiter.sv
// ---------------------------------------------------------------------------
// scanner_link_arbiter
// Round-robin owner of the shared scanner serial link. Two channels request
// with level-sensitive req; the winner's frame (command byte, optionally a
// data byte) is serialised LSB-first by scanner_link_serializer, followed by
// GAP_CYCLES idle cycles.
//   clk   system clock
//   rst   asynchronous active-high reset
//   lnk   scanner_link_arbiter_if.slave (requests in, grant/done/link out)
// Parameters: BIT_DIV (clk cycles per bit, even, >=2), GAP_CYCLES (>=0).
// Optional feature macro: SCANNER_LINK_PARITY_EN.
// ---------------------------------------------------------------------------
module scanner_link_arbiter
    import scanner_link_pkg::*;
#(
    parameter int BIT_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    scanner_link_arbiter_if.slave lnk
);

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t               state;
    logic                 last_served;
    logic [1:0]           grant_q;
    logic [1:0]           done_q;
    logic                 busy_q;
    logic [GAP_W-1:0]     gap_cnt;

    logic                 win;
    logic                 start;
    logic                 last_bit;
    logic                 has_sel;
    logic [7:0]           cmd_sel;
    logic [7:0]           data_sel;
    logic [BIT_CNT_W-1:0] len_sel;

    // A lone requester always wins; on a tie the channel not served last wins.
    always_comb begin
        win = 1'b0;
        case (lnk.req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = ~last_served;
        endcase
    end

    assign start    = (state == IDLE) && (lnk.req != 2'b00);
    assign has_sel  = win ? lnk.req_has_data[1] : lnk.req_has_data[0];
    assign cmd_sel  = win ? lnk.req_cmd1  : lnk.req_cmd0;
    assign data_sel = win ? lnk.req_data1 : lnk.req_data0;
    assign len_sel  = has_sel ? LEN_CMD_DATA : LEN_CMD;

    scanner_link_serializer #(
        .BIT_DIV (BIT_DIV)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (start),
        .frame_len (len_sel),
        .cmd       (cmd_sel),
        .data      (data_sel),
        .last_bit  (last_bit),
        .link_clk  (lnk.link_clk),
        .link_data (lnk.link_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            grant_q     <= 2'b00;
            done_q      <= 2'b00;
            busy_q      <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            done_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SHIFT;
                        grant_q     <= win ? 2'b10 : 2'b01;
                        last_served <= win;
                        busy_q      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        done_q  <= grant_q;
                        grant_q <= 2'b00;
                        gap_cnt <= '0;
                        if (GAP_CYCLES == 0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign lnk.grant     = grant_q;
    assign lnk.done      = done_q;
    assign lnk.link_busy = busy_q;

endmodule

// File: tb/tb_scanner_link_arbiter.sv
// ---------------------------------------------------------------------------
// tb_scanner_link_arbiter
// Scoreboard bench: stimulus pushes the expected frame (channel, bits,
// length) into a queue; a negedge monitor reconstructs each frame from
// link_clk/link_data and compares it when done pulses.
// ---------------------------------------------------------------------------
module tb_scanner_link_arbiter;
    import scanner_link_pkg::*;

    localparam int BIT_DIV    = 4;
    localparam int GAP_CYCLES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    scanner_link_arbiter_if lnk();

    scanner_link_arbiter #(
        .BIT_DIV    (BIT_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lnk (lnk.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [17:0] bits;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] ch, input logic [7:0] c,
                                input logic [7:0] d, input logic hd);
        exp_t e;
        e.ch = ch;
`ifdef SCANNER_LINK_PARITY_EN
        e.bits = hd ? {^d, d, ^c, c} : {9'b0, ^c, c};
        e.len  = hd ? 18 : 9;
`else
        e.bits = hd ? {2'b0, d, c} : {10'b0, c};
        e.len  = hd ? 16 : 8;
`endif
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic [17:0] cap;
    int          nbits;
    int          cyc;
    int          gapc;
    logic        prev_clk;
    logic [1:0]  gseen;

    always @(negedge clk) begin
        if (rst) begin
            cap = '0; nbits = 0; cyc = 0; gapc = 0; prev_clk = 1'b0; gseen = 2'b00;
        end else begin
            if (lnk.link_busy && lnk.grant != 2'b00) begin
                cyc++;
                gseen = lnk.grant;
            end
            if (lnk.link_clk && !prev_clk) begin
                if (nbits < 18) cap[nbits] = lnk.link_data;
                nbits++;
            end
            prev_clk = lnk.link_clk;
            if (lnk.link_busy && lnk.grant == 2'b00) begin
                gapc++;
            end else if (gapc != 0) begin
                chk("gap_len", 32'(gapc), 32'(GAP_CYCLES));
                gapc = 0;
            end
            if (lnk.done != 2'b00) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=%b, expected no frame", lnk.done);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_chan",   32'(lnk.done), 32'(e.ch));
                    chk("grant_chan",  32'(gseen),    32'(e.ch));
                    chk("frame_bits",  32'(nbits),    32'(e.len));
                    chk("frame_data",  32'(cap),      32'(e.bits));
                    chk("frame_cycles", 32'(cyc),     32'(e.len * BIT_DIV));
                end
                cap = '0; nbits = 0; cyc = 0; gseen = 2'b00;
            end
        end
    end

    // Runs until all expected frames are seen and the link is idle. Requesters
    // drop req on done; with hold set, req stays high until the last frame.
    task automatic drain(input int budget, input bit hold);
        int n = 0;
        while ((sb.size() != 0 || lnk.link_busy) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (lnk.done != 2'b00) begin
                if (hold) begin
                    if (sb.size() == 0) lnk.req = 2'b00;
                end else begin
                    lnk.req = lnk.req & ~lnk.done;
                end
            end
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL drain_timeout: %0d cycles used, %0d frames pending, limit %0d",
                     n, sb.size(), budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        lnk.req = 2'b00; lnk.req_has_data = 2'b00;
        lnk.req_cmd0 = 8'h00; lnk.req_cmd1 = 8'h00;
        lnk.req_data0 = 8'h00; lnk.req_data1 = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(lnk.grant),     32'd0);
        chk("rst_done",  32'(lnk.done),      32'd0);
        chk("rst_clk",   32'(lnk.link_clk),  32'd0);
        chk("rst_data",  32'(lnk.link_data), 32'd0);
        chk("rst_busy",  32'(lnk.link_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // single channel 0 frame, START command, first-bit latency
        @(negedge clk);
        lnk.req_cmd0 = CMD_START;
        lnk.req = 2'b01;
        sb.push_back(mk(2'b01, CMD_START, 8'h00, 1'b0));
        @(posedge clk);
        #1;
        chk("lat_grant", 32'(lnk.grant),     32'd1);
        chk("lat_data",  32'(lnk.link_data), 32'd1);
        chk("lat_clk",   32'(lnk.link_clk),  32'd1);
        chk("lat_busy",  32'(lnk.link_busy), 32'd1);
        drain(400, 1'b0);

        // both requesting from reset: strict alternation 01,10,01,10
        @(negedge clk);
        rst = 1'b1;
        lnk.req_cmd0 = CMD_READY;
        lnk.req_cmd1 = CMD_FULL;
        lnk.req = 2'b11;
        sb.push_back(mk(2'b01, CMD_READY, 8'h00, 1'b0));
        sb.push_back(mk(2'b10, CMD_FULL,  8'h00, 1'b0));
        sb.push_back(mk(2'b01, CMD_READY, 8'h00, 1'b0));
        sb.push_back(mk(2'b10, CMD_FULL,  8'h00, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        drain(1000, 1'b1);

        // channel 1 with a data byte: 07 then A5
        @(negedge clk);
        lnk.req_has_data = 2'b10;
        lnk.req_cmd1 = CMD_DATA;
        lnk.req_data1 = 8'hA5;
        lnk.req = 2'b10;
        sb.push_back(mk(2'b10, CMD_DATA, 8'hA5, 1'b1));
        drain(500, 1'b0);
        lnk.req_has_data = 2'b00;

        // async reset at bit 3 of a frame, then tie resolved to channel 0
        @(negedge clk);
        lnk.req_cmd0 = CMD_START;
        lnk.req = 2'b01;
        @(posedge clk);
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_clk",   32'(lnk.link_clk),  32'd0);
        chk("abort_data",  32'(lnk.link_data), 32'd0);
        chk("abort_grant", 32'(lnk.grant),     32'd0);
        chk("abort_busy",  32'(lnk.link_busy), 32'd0);
        @(negedge clk);
        lnk.req_cmd0 = CMD_READY;
        lnk.req_cmd1 = CMD_FULL;
        lnk.req = 2'b11;
        sb.push_back(mk(2'b01, CMD_READY, 8'h00, 1'b0));
        sb.push_back(mk(2'b10, CMD_FULL,  8'h00, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        drain(800, 1'b0);

        // req and payload changed mid-frame: latched frame still completes
        @(negedge clk);
        lnk.req_cmd0 = CMD_FULL;
        lnk.req = 2'b01;
        sb.push_back(mk(2'b01, CMD_FULL, 8'h00, 1'b0));
        repeat (10) @(negedge clk);
        lnk.req = 2'b00;
        lnk.req_cmd0 = 8'hFF;
        lnk.req_has_data = 2'b01;
        lnk.req_data0 = 8'h3C;
        drain(400, 1'b0);
        lnk.req_has_data = 2'b00;

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
